// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: decoded instruction record and issue-stage FSM states.
package riscv_pkg;

    localparam int NUM_ARCH_REGS = 32;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } idu_t;

    typedef enum logic {
        ISSUE_IDLE = 1'b0,
        ISSUE_WAIT = 1'b1
    } issue_state_e;

endpackage

// File: rtl/riscv_exu_issue_fifo.sv
// Synchronous FIFO of decoded instructions; flush empties it and drops a same-cycle push.
module riscv_exu_issue_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  idu_t din,
    output idu_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    idu_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (!reset && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/riscv_exu_issue.sv
// Issue stage: queues IDU instructions, owns the register file, issues one at a time to the ALU.
// Optional macro RISCV_ISSUE_FWD_EN: write-back forwarding and issue in the alu_done cycle.
module riscv_exu_issue
    import riscv_pkg::*;
#(
    parameter int IBUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        idu_vld,
    input  idu_t        idu,
    output logic        idu_rdy,
    input  logic        alu_done,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        alu_vld,
    output idu_t        alu_idu,
    output logic [31:0] alu_rs1_data,
    output logic [31:0] alu_rs2_data,
    output logic        busy
);

    issue_state_e state;
    logic [31:0]  regs [NUM_ARCH_REGS];
    idu_t         fifo_head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         issue;
    logic [31:0]  rs1_val;
    logic [31:0]  rs2_val;

    assign idu_rdy = !fifo_full;
    assign busy    = (state == ISSUE_WAIT) || !fifo_empty;

`ifdef RISCV_ISSUE_FWD_EN
    assign issue = !fifo_empty && !flush && ((state == ISSUE_IDLE) || alu_done);
`else
    assign issue = !fifo_empty && !flush && (state == ISSUE_IDLE);
`endif

    riscv_exu_issue_fifo #(.DEPTH(IBUF_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (idu_vld),
        .pop   (issue),
        .din   (idu),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) regs[i] <= '0;
        end else if (wb_en && (wb_rd != '0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Operand read for the queue head; forwarding covers a write landing in the issue cycle.
    always_comb begin
        rs1_val = (fifo_head.rs1 == '0) ? '0 : regs[fifo_head.rs1];
        rs2_val = (fifo_head.rs2 == '0) ? '0 : regs[fifo_head.rs2];
`ifdef RISCV_ISSUE_FWD_EN
        if (wb_en && (wb_rd != '0) && (wb_rd == fifo_head.rs1)) rs1_val = wb_data;
        if (wb_en && (wb_rd != '0) && (wb_rd == fifo_head.rs2)) rs2_val = wb_data;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ISSUE_IDLE;
            alu_vld      <= 1'b0;
            alu_idu      <= '0;
            alu_rs1_data <= '0;
            alu_rs2_data <= '0;
        end else begin
            alu_vld <= issue;
            if (issue) begin
                alu_idu      <= fifo_head;
                alu_rs1_data <= rs1_val;
                alu_rs2_data <= rs2_val;
            end
            case (state)
                ISSUE_IDLE: if (issue) state <= ISSUE_WAIT;
                ISSUE_WAIT: if (alu_done && !issue) state <= ISSUE_IDLE;
                default:    state <= ISSUE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_exu_issue.sv
// Self-checking bench for riscv_exu_issue: operand vector table plus directed multi-cycle sequences.
module tb_riscv_exu_issue;
    import riscv_pkg::*;

    localparam int IBUF_DEPTH = 2;
    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] OP_REG = 7'h33;
`ifdef RISCV_ISSUE_FWD_EN
    localparam int EXP_GAP = 2;
`else
    localparam int EXP_GAP = 3;
`endif

    logic        clock;
    logic        reset;
    logic        flush;
    logic        idu_vld;
    idu_t        idu;
    logic        idu_rdy;
    logic        alu_done;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        alu_vld;
    idu_t        alu_idu;
    logic [31:0] alu_rs1_data;
    logic [31:0] alu_rs2_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    riscv_exu_issue #(.IBUF_DEPTH(IBUF_DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .idu_vld      (idu_vld),
        .idu          (idu),
        .idu_rdy      (idu_rdy),
        .alu_done     (alu_done),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .alu_vld      (alu_vld),
        .alu_idu      (alu_idu),
        .alu_rs1_data (alu_rs1_data),
        .alu_rs2_data (alu_rs2_data),
        .busy         (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp_rs1;
        logic [31:0] exp_rs2;
    } vec_t;

    vec_t vecs [5];

    function automatic idu_t mk_instr(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [31:0] imm);
        idu_t t;
        t        = '0;
        t.opcode = op;
        t.rd     = rd;
        t.rs1    = rs1;
        t.rs2    = rs2;
        t.imm    = imm;
        return t;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic vld, input idu_t instr, input logic done,
                                 input logic wen, input logic [4:0] wrd,
                                 input logic [31:0] wdata, input logic fl);
        idu_vld  = vld;
        idu      = instr;
        alu_done = done;
        wb_en    = wen;
        wb_rd    = wrd;
        wb_data  = wdata;
        flush    = fl;
    endtask

    task automatic idle_inputs();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Looks at the current cycle first, then advances until alu_vld or the budget runs out.
    task automatic wait_vld(input int max, output int n, input string name);
        n = 0;
        while (!alu_vld && n < max) begin
            tick();
            n++;
        end
        checkOutput(name, 32'(alu_vld), 32'd1);
    endtask

    // Called in the alu_vld cycle: ALU reports done one cycle later.
    task automatic finish_inflight(input logic wen, input logic [4:0] wrd, input logic [31:0] wdata);
        tick();
        applyStimulus(1'b0, '0, 1'b1, wen, wrd, wdata, 1'b0);
        tick();
        idle_inputs();
    endtask

    task automatic push_three(input logic [4:0] base_rd);
        applyStimulus(1'b1, mk_instr(OP_REG, base_rd, 5'd0, 5'd0, 32'd0), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b1, mk_instr(OP_REG, base_rd + 5'd1, 5'd0, 5'd0, 32'd0), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b1, mk_instr(OP_REG, base_rd + 5'd2, 5'd0, 5'd0, 32'd0), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        idle_inputs();
    endtask

    initial begin
        int n;
        int vld_count;

        reset = 1'b1;
        idle_inputs();

        vecs[0] = '{5'd3,  32'h1234_5678, 5'd3,  5'd0,  32'h1234_5678, 32'h0000_0000};
        vecs[1] = '{5'd0,  32'hDEAD_BEEF, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
        vecs[2] = '{5'd31, 32'hFFFF_FFFF, 5'd31, 5'd3,  32'hFFFF_FFFF, 32'h1234_5678};
        vecs[3] = '{5'd3,  32'hA5A5_A5A5, 5'd3,  5'd31, 32'hA5A5_A5A5, 32'hFFFF_FFFF};
        vecs[4] = '{5'd0,  32'h0000_0001, 5'd0,  5'd31, 32'h0000_0000, 32'hFFFF_FFFF};

        do_reset();
        checkOutput("reset idu_rdy", 32'(idu_rdy), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset alu_vld", 32'(alu_vld), 32'd0);
        checkOutput("reset alu_rs1_data", alu_rs1_data, 32'd0);
        checkOutput("reset alu_rs2_data", alu_rs2_data, 32'd0);
        checkOutput("reset alu_idu zero", 32'(alu_idu == '0), 32'd1);

        // Single ADDI: issue latency and busy release.
        applyStimulus(1'b1, mk_instr(OP_IMM, 5'd1, 5'd0, 5'd0, 32'd5), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        idle_inputs();
        checkOutput("t1 c1 alu_vld", 32'(alu_vld), 32'd0);
        tick();
        checkOutput("t1 c2 alu_vld", 32'(alu_vld), 32'd1);
        checkOutput("t1 c2 rs1", alu_rs1_data, 32'd0);
        checkOutput("t1 c2 imm", alu_idu.imm, 32'd5);
        checkOutput("t1 c2 busy", 32'(busy), 32'd1);
        tick();
        checkOutput("t1 c3 alu_vld", 32'(alu_vld), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 5'd1, 32'd5, 1'b0);
        tick();
        idle_inputs();
        checkOutput("t1 c4 busy", 32'(busy), 32'd0);
        checkOutput("t1 c4 alu_vld", 32'(alu_vld), 32'd0);

        // Dependent back-to-back pair.
        do_reset();
        applyStimulus(1'b1, mk_instr(OP_IMM, 5'd1, 5'd0, 5'd0, 32'd5), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b1, mk_instr(OP_REG, 5'd2, 5'd1, 5'd1, 32'd0), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        idle_inputs();
        checkOutput("t2 first alu_vld", 32'(alu_vld), 32'd1);
        finish_inflight(1'b1, 5'd1, 32'd5);
        wait_vld(6, n, "t2 second alu_vld");
        checkOutput("t2 issue gap", 32'(2 + n), 32'(EXP_GAP));
        checkOutput("t2 rs1", alu_rs1_data, 32'd5);
        checkOutput("t2 rs2", alu_rs2_data, 32'd5);
        checkOutput("t2 rd", 32'(alu_idu.rd), 32'd2);
        finish_inflight(1'b1, 5'd2, 32'd10);

        // Operand table: write a register, then issue a read of it.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1, vecs[i].wb_rd, vecs[i].wb_data, 1'b0);
            tick();
            applyStimulus(1'b1, mk_instr(OP_REG, 5'd9, vecs[i].rs1, vecs[i].rs2, 32'd0),
                          1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
            tick();
            idle_inputs();
            wait_vld(6, n, $sformatf("vec%0d alu_vld", i));
            checkOutput($sformatf("vec%0d rs1", i), alu_rs1_data, vecs[i].exp_rs1);
            checkOutput($sformatf("vec%0d rs2", i), alu_rs2_data, vecs[i].exp_rs2);
            finish_inflight(1'b0, 5'd0, 32'd0);
        end

        // Queue fills while the ALU stalls; a rejected push must not appear later.
        do_reset();
        applyStimulus(1'b1, mk_instr(OP_REG, 5'd11, 5'd0, 5'd0, 32'd0), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b1, mk_instr(OP_REG, 5'd12, 5'd0, 5'd0, 32'd0), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        checkOutput("t4 first issue", 32'(alu_vld), 32'd1);
        checkOutput("t4 first rd", 32'(alu_idu.rd), 32'd11);
        applyStimulus(1'b1, mk_instr(OP_REG, 5'd13, 5'd0, 5'd0, 32'd0), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b1, mk_instr(OP_REG, 5'd14, 5'd0, 5'd0, 32'd0), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("t4 idu_rdy full", 32'(idu_rdy), 32'd0);
        tick();
        idle_inputs();
        checkOutput("t4 idu_rdy held", 32'(idu_rdy), 32'd0);
        finish_inflight(1'b0, 5'd0, 32'd0);
        wait_vld(6, n, "t4 second alu_vld");
        checkOutput("t4 second rd", 32'(alu_idu.rd), 32'd12);
        finish_inflight(1'b0, 5'd0, 32'd0);
        wait_vld(6, n, "t4 third alu_vld");
        checkOutput("t4 third rd", 32'(alu_idu.rd), 32'd13);
        finish_inflight(1'b0, 5'd0, 32'd0);
        vld_count = 0;
        for (int i = 0; i < 6; i++) begin
            if (alu_vld) vld_count++;
            tick();
        end
        checkOutput("t4 no extra issue", 32'(vld_count), 32'd0);
        checkOutput("t4 busy idle", 32'(busy), 32'd0);

        // Flush in WAIT with two queued; in-flight write-back still lands.
        do_reset();
        push_three(5'd20);
        checkOutput("t5 busy before flush", 32'(busy), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        tick();
        idle_inputs();
        checkOutput("t5 busy in wait", 32'(busy), 32'd1);
        checkOutput("t5 idu_rdy after flush", 32'(idu_rdy), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 5'd5, 32'd7, 1'b0);
        tick();
        idle_inputs();
        checkOutput("t5 busy after done", 32'(busy), 32'd0);
        vld_count = 0;
        for (int i = 0; i < 4; i++) begin
            if (alu_vld) vld_count++;
            tick();
        end
        checkOutput("t5 no issue after flush", 32'(vld_count), 32'd0);
        applyStimulus(1'b1, mk_instr(OP_REG, 5'd6, 5'd5, 5'd0, 32'd0), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        idle_inputs();
        wait_vld(6, n, "t5 read alu_vld");
        checkOutput("t5 x5 value", alu_rs1_data, 32'd7);
        finish_inflight(1'b0, 5'd0, 32'd0);

        // Reset in WAIT with a queue and a live register.
        do_reset();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 5'd1, 32'd5, 1'b0);
        tick();
        push_three(5'd24);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("t6 alu_vld", 32'(alu_vld), 32'd0);
        checkOutput("t6 idu_rdy", 32'(idu_rdy), 32'd1);
        checkOutput("t6 busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        idle_inputs();
        checkOutput("t6 stray done c1", 32'(alu_vld), 32'd0);
        tick();
        checkOutput("t6 stray done c2", 32'(alu_vld), 32'd0);
        applyStimulus(1'b1, mk_instr(OP_REG, 5'd7, 5'd1, 5'd1, 32'd0), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        idle_inputs();
        wait_vld(6, n, "t6 read alu_vld");
        checkOutput("t6 x1 rs1", alu_rs1_data, 32'd0);
        checkOutput("t6 x1 rs2", alu_rs2_data, 32'd0);
        finish_inflight(1'b0, 5'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_exu_issue.md
Name: riscv_exu_issue

Overview:
- Issue stage directly upstream of the ALU execute unit.
- Queues decoded instructions (riscv_pkg::idu_t) from the IDU, owns the 32x32 architectural register file and reads operands.
- Issues exactly one instruction at a time to the ALU as a single-cycle vld pulse, then waits for the ALU's done before issuing the next.
- Writes ALU results back into the register file.

Parameters:
IBUF_DEPTH, 2, input queue depth in entries; power of two, at least 2

Ports:
clock  input  1  core clock
reset  input  1  reset
flush  input  1  discard all queued (not yet issued) instructions
idu_vld  input  1  IDU offers an instruction
idu  input  riscv_pkg::idu_t  decoded instruction
idu_rdy  output  1  queue can accept; equals not-full
alu_done  input  1  ALU completed the in-flight instruction
wb_en  input  1  ALU register write enable
wb_rd  input  5  ALU destination register
wb_data  input  32  ALU write data
alu_vld  output  1  single-cycle issue pulse to the ALU
alu_idu  output  riscv_pkg::idu_t  issued instruction
alu_rs1_data  output  32  rs1 operand value
alu_rs2_data  output  32  rs2 operand value
busy  output  1  instruction queued or in flight

Behaviour:
- Clock and reset (already decided): reset reset, synchronous, active-high; clock clock.
- Reset values:
  - queue empty, idu_rdy=1
  - state IDLE, busy=0, alu_vld=0
  - alu_idu=0, alu_rs1_data=0, alu_rs2_data=0
  - all 32 registers = 0
  - reset overrides every other input in that cycle, including mid-WAIT; a later alu_done for the killed instruction is ignored in IDLE.
- Queue:
  - Push when idu_vld && idu_rdy.
  - idu_rdy = !full, derived from the registered count only. A pop in the same cycle does not make a full queue ready.
  - An entry pushed in cycle N is issuable no earlier than cycle N+1.
- Register file:
  - Written at the clock edge when wb_en=1.
  - wb_rd=0 writes are ignored; x0 always reads 0.
  - wb_en is accepted in any state.
- FSM states: IDLE, WAIT.
  - IDLE: if queue non-empty and !flush, pop the head, register alu_idu, rs1/rs2 data and alu_vld=1 for the next cycle, then go to WAIT. Otherwise stay in IDLE.
  - WAIT: alu_vld is high only in the first WAIT cycle and 0 afterwards. Wait for alu_done.
  - On alu_done: go to IDLE. The next instruction issues from IDLE one cycle later (see Optional Feature for same-cycle issue).
- Operand outputs and alu_idu hold their last issued value until the next issue.
- Throughput: one instruction per 3 cycles (issue, done, IDLE) without forwarding; one per 2 with RISCV_ISSUE_FWD_EN.
- Flush:
  - Queue empties at the edge; a push in the flush cycle is dropped; no issue occurs in the flush cycle.
  - An in-flight instruction is not cancelled: the FSM stays in WAIT until alu_done, and its write-back still happens.
- busy = (state==WAIT) || queue non-empty. It is 0 the cycle after the final done with an empty queue.

Optional Feature:
Macro RISCV_ISSUE_FWD_EN.
- Defined:
  - Operand reads forward wb_data when wb_en && wb_rd!=0 && wb_rd==rs in the same cycle; rs1 and rs2 are handled independently.
  - In WAIT, the cycle with alu_done and a non-empty queue (and !flush) issues the next instruction directly. The FSM stays in WAIT, and alu_vld is high in the following cycle.
- Undefined:
  - No forwarding; alu_done always returns the FSM to IDLE.
  - The regfile write has landed before the IDLE read, so operands are still correct, at one extra cycle per instruction.

Decomposition:
- riscv_pkg gains:
  - enum issue_state_e {ISSUE_IDLE, ISSUE_WAIT}
  - localparam NUM_ARCH_REGS=32
- idu_t is reused unchanged.
- One sub-module: riscv_exu_issue_fifo, a generic synchronous FIFO of idu_t with push, pop, flush, full, empty and a DEPTH parameter.

Test Plan:
1. After reset, push ADDI x1,x0,5 at cycle 0 -> alu_vld=1 exactly in cycle 2, alu_rs1_data=0; ALU returns done, wb x1=5 in cycle 3 -> busy=0 in cycle 4.
2. ADDI x1,x0,5 then ADD x2,x1,x1 back-to-back, ALU done one cycle after each vld:
   - with FWD_EN: second alu_vld 2 cycles after the first, alu_rs1_data=alu_rs2_data=5
   - without FWD_EN: second alu_vld 3 cycles after the first, same operand values
3. wb_en=1, wb_rd=0, wb_data=0xDEADBEEF, then issue ADD x3,x0,x0 -> alu_rs1_data=alu_rs2_data=0.
4. Hold alu_done=0 and push IBUF_DEPTH+1 instructions (default 3; one pops on issue) -> after 3 accepted, idu_rdy=0; a further push is not accepted and the queue contents are unchanged.
5. In WAIT with 2 queued, pulse flush, then done with wb x5=7 -> no further alu_vld, x5 later reads 7, busy=0 the cycle after done.
6. Assert reset during WAIT with 2 queued and x1=5 -> next cycle alu_vld=0, idu_rdy=1, busy=0; a later issue reading x1 gives 0; a stray alu_done does not cause alu_vld.
